// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg
// Shared definitions for the BRAM port arbiter: arbiter state encoding,
// read-tag owner values, the {valid, owner} read-tag record and the default
// BRAM geometry.
package mem_arb_pkg;

  localparam int ADDR_WIDTH_DEF = 16;
  localparam int DATA_WIDTH_DEF = 32;

  localparam logic [1:0] ENC_CPU_OWN = 2'd0;
  localparam logic [1:0] ENC_DRAIN   = 2'd1;
  localparam logic [1:0] ENC_DBG_OWN = 2'd2;
  localparam logic [1:0] ENC_RETURN  = 2'd3;

  typedef enum logic [1:0] {
    CPU_OWN = ENC_CPU_OWN,
    DRAIN   = ENC_DRAIN,
    DBG_OWN = ENC_DBG_OWN,
    RETURN  = ENC_RETURN
  } arb_state_t;

  localparam logic OWNER_CPU = 1'b0;
  localparam logic OWNER_DBG = 1'b1;

  typedef struct packed {
    logic valid;
    logic owner;
  } rd_tag_t;

endpackage

// File: rtl/mem_port_arbiter_rd_tag_pipe.sv
// rd_tag_pipe
// RD_LATENCY-deep shift register of {valid, owner} read tags. A tag entered
// alongside a BRAM read address emerges at tag_out in the same cycle the BRAM
// presents the matching dob word.
//
// Ports:
//   clk, rst_n     clock, synchronous active-low reset (clears all tags)
//   tag_in         tag for the read issued this cycle
//   tag_out        tag whose data is on dob this cycle
//   cpu_in_flight  a CPU tag is still to return in a later cycle
//   dbg_in_flight  a debug tag is still to return in a later cycle
module rd_tag_pipe
  import mem_arb_pkg::*;
#(
  parameter int RD_LATENCY = 1
) (
  input  logic    clk,
  input  logic    rst_n,
  input  rd_tag_t tag_in,
  output rd_tag_t tag_out,
  output logic    cpu_in_flight,
  output logic    dbg_in_flight
);

  rd_tag_t pipe [RD_LATENCY];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < RD_LATENCY; i++) pipe[i] <= '0;
    end else begin
      pipe[0] <= tag_in;
      for (int i = 1; i < RD_LATENCY; i++) pipe[i] <= pipe[i-1];
    end
  end

  assign tag_out = pipe[RD_LATENCY-1];

  // The output stage is returning this cycle, so it no longer blocks an
  // ownership change; only stages still upstream of it count as in flight.
  always_comb begin
    cpu_in_flight = 1'b0;
    dbg_in_flight = 1'b0;
    for (int i = 0; i < RD_LATENCY - 1; i++) begin
      if (pipe[i].valid && (pipe[i].owner == OWNER_CPU)) cpu_in_flight = 1'b1;
      if (pipe[i].valid && (pipe[i].owner == OWNER_DBG)) dbg_in_flight = 1'b1;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares the dual-port instruction/data BRAM between the CPU core and the
// UART debug loader. The CPU owns both ports by default; the debug loader is
// granted them only after the CPU is stalled and its reads have returned.
// Read data is steered back to whichever side issued the read address.
//
// Optional build macro MEM_ARB_WATCHDOG_EN: forces a debug session back to
// the CPU after TIMEOUT_CYCLES idle cycles in DBG_OWN and pulses dbg_timeout.
//
// Ports:
//   clk, rst_n                          clock, synchronous active-low reset
//   cpu_addra/cpu_wea/cpu_dia           CPU write port
//   cpu_re/cpu_addrb                    CPU read strobe and address
//   cpu_dob/cpu_rvalid                  CPU read data, valid pulse
//   cpu_stall                           CPU must hold its current access
//   dbg_req/dbg_gnt                     debug session request (level) / grant
//   dbg_addra/dbg_wea/dbg_dia           debug write port
//   dbg_re/dbg_addrb                    debug read strobe and address
//   dbg_dob/dbg_rvalid                  debug read data, valid pulse
//   dbg_timeout                         session force-released by watchdog
//   addra/wea/dia                       BRAM port A (write)
//   addrb/dob                           BRAM port B (read)
//
// State table:
//   CPU_OWN | CPU drives both BRAM ports, no stall
//   DRAIN   | CPU stalled, writes blocked, waiting for CPU reads to return
//   DBG_OWN | debug loader drives both BRAM ports
//   RETURN  | CPU still stalled, waiting for debug reads to return
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_WIDTH     = ADDR_WIDTH_DEF,
  parameter int DATA_WIDTH     = DATA_WIDTH_DEF,
  parameter int DRAIN_CYCLES   = 2,
  parameter int RD_LATENCY     = 1,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [ADDR_WIDTH-1:0]   cpu_addra,
  input  logic [DATA_WIDTH/8-1:0] cpu_wea,
  input  logic [DATA_WIDTH-1:0]   cpu_dia,
  input  logic                    cpu_re,
  input  logic [ADDR_WIDTH-1:0]   cpu_addrb,
  output logic [DATA_WIDTH-1:0]   cpu_dob,
  output logic                    cpu_rvalid,
  output logic                    cpu_stall,
  input  logic                    dbg_req,
  output logic                    dbg_gnt,
  input  logic [ADDR_WIDTH-1:0]   dbg_addra,
  input  logic [DATA_WIDTH/8-1:0] dbg_wea,
  input  logic [DATA_WIDTH-1:0]   dbg_dia,
  input  logic                    dbg_re,
  input  logic [ADDR_WIDTH-1:0]   dbg_addrb,
  output logic [DATA_WIDTH-1:0]   dbg_dob,
  output logic                    dbg_rvalid,
  output logic                    dbg_timeout,
  output logic [ADDR_WIDTH-1:0]   addra,
  output logic [DATA_WIDTH/8-1:0] wea,
  output logic [DATA_WIDTH-1:0]   dia,
  output logic [ADDR_WIDTH-1:0]   addrb,
  input  logic [DATA_WIDTH-1:0]   dob
);

  localparam int BW  = DATA_WIDTH / 8;
  localparam int DCW = $clog2(DRAIN_CYCLES + 1) + 1;
  localparam logic [DCW-1:0] DRAIN_TC = DCW'((DRAIN_CYCLES > 0) ? DRAIN_CYCLES - 1 : 0);

  arb_state_t state_q, state_d;
  logic [DCW-1:0] drain_cnt_q;

  rd_tag_t tag_in, tag_out;
  logic    cpu_in_flight, dbg_in_flight;

  logic wd_timeout;
  logic session_ok;

  logic [ADDR_WIDTH-1:0] addra_d, addrb_d;
  logic [BW-1:0]         wea_d;
  logic [DATA_WIDTH-1:0] dia_d;
  logic                  stall_d, gnt_d;

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= CPU_OWN;
    else        state_q <= state_d;
  end

  // Saturating so a long stay in DRAIN (CPU read slow to return) cannot wrap.
  always_ff @(posedge clk) begin
    if (!rst_n)                  drain_cnt_q <= '0;
    else if (state_q != DRAIN)   drain_cnt_q <= '0;
    else if (drain_cnt_q != '1)  drain_cnt_q <= drain_cnt_q + 1'b1;
  end

`ifdef MEM_ARB_WATCHDOG_EN
  localparam int WCW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [WCW-1:0] WD_TC = WCW'(TIMEOUT_CYCLES);

  logic [WCW-1:0] wd_cnt_q;
  logic           wd_lock_q;
  logic           dbg_active;

  assign dbg_active = dbg_re || (|dbg_wea);
  assign wd_timeout = (state_q == DBG_OWN) && !dbg_active && (wd_cnt_q == WD_TC);

  // After a forced release the loader must drop dbg_req before it may ask
  // again; otherwise a hung loader would immediately re-grab the BRAM.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wd_cnt_q  <= '0;
      wd_lock_q <= 1'b0;
    end else begin
      if ((state_q != DBG_OWN) || dbg_active) wd_cnt_q <= '0;
      else if (wd_cnt_q != WD_TC)             wd_cnt_q <= wd_cnt_q + 1'b1;
      if (wd_timeout)    wd_lock_q <= 1'b1;
      else if (!dbg_req) wd_lock_q <= 1'b0;
    end
  end

  assign session_ok = !wd_lock_q;
`else
  logic unused_timeout_param;
  assign unused_timeout_param = |TIMEOUT_CYCLES;
  assign wd_timeout = 1'b0;
  assign session_ok = 1'b1;
`endif

  always_comb begin
    state_d  = state_q;
    addra_d  = cpu_addra;
    dia_d    = cpu_dia;
    addrb_d  = cpu_addrb;
    wea_d    = '0;
    stall_d  = 1'b0;
    gnt_d    = 1'b0;
    tag_in   = '0;
    case (state_q)
      CPU_OWN: begin
        wea_d        = cpu_wea;
        tag_in.valid = cpu_re;
        tag_in.owner = OWNER_CPU;
        if (dbg_req && session_ok) state_d = DRAIN;
      end
      DRAIN: begin
        stall_d = 1'b1;
        if (!dbg_req)
          state_d = CPU_OWN;
        else if ((drain_cnt_q >= DRAIN_TC) && !cpu_in_flight)
          state_d = DBG_OWN;
      end
      DBG_OWN: begin
        stall_d      = 1'b1;
        gnt_d        = 1'b1;
        addra_d      = dbg_addra;
        wea_d        = dbg_wea;
        dia_d        = dbg_dia;
        addrb_d      = dbg_addrb;
        tag_in.valid = dbg_re;
        tag_in.owner = OWNER_DBG;
        if (!dbg_req || wd_timeout) state_d = RETURN;
      end
      RETURN: begin
        stall_d = 1'b1;
        if (!dbg_in_flight) state_d = CPU_OWN;
      end
      default: state_d = CPU_OWN;
    endcase
  end

  rd_tag_pipe #(
    .RD_LATENCY(RD_LATENCY)
  ) u_rd_tag_pipe (
    .clk          (clk),
    .rst_n        (rst_n),
    .tag_in       (tag_in),
    .tag_out      (tag_out),
    .cpu_in_flight(cpu_in_flight),
    .dbg_in_flight(dbg_in_flight)
  );

  // Outputs are forced to their idle values while rst_n is low so a reset
  // drops the grant and blocks writes in the same cycle, not one later.
  assign addra       = rst_n ? addra_d : '0;
  assign wea         = rst_n ? wea_d   : '0;
  assign dia         = rst_n ? dia_d   : '0;
  assign addrb       = rst_n ? addrb_d : '0;
  assign cpu_stall   = rst_n && stall_d;
  assign dbg_gnt     = rst_n && gnt_d;
  assign dbg_timeout = rst_n && wd_timeout;

  assign cpu_rvalid = rst_n && tag_out.valid && (tag_out.owner == OWNER_CPU);
  assign dbg_rvalid = rst_n && tag_out.valid && (tag_out.owner == OWNER_DBG);
  assign cpu_dob    = rst_n ? dob : '0;
  assign dbg_dob    = rst_n ? dob : '0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;
  localparam int AW = 16;
  localparam int DW = 32;
`ifdef MEM_ARB_WATCHDOG_EN
  localparam int TB_TIMEOUT = 8;
`else
  localparam int TB_TIMEOUT = 65535;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic [AW-1:0] cpu_addra, cpu_addrb, dbg_addra, dbg_addrb, addra, addrb;
  logic [3:0]    cpu_wea, dbg_wea, wea;
  logic [DW-1:0] cpu_dia, dbg_dia, dia, cpu_dob, dbg_dob, dob;
  logic          cpu_re, cpu_rvalid, cpu_stall;
  logic          dbg_req, dbg_gnt, dbg_re, dbg_rvalid, dbg_timeout;

  int n_pass = 0;
  int n_total = 0;

  mem_port_arbiter #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DRAIN_CYCLES(2), .RD_LATENCY(1),
    .TIMEOUT_CYCLES(TB_TIMEOUT)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_addra(cpu_addra), .cpu_wea(cpu_wea), .cpu_dia(cpu_dia),
    .cpu_re(cpu_re), .cpu_addrb(cpu_addrb), .cpu_dob(cpu_dob),
    .cpu_rvalid(cpu_rvalid), .cpu_stall(cpu_stall),
    .dbg_req(dbg_req), .dbg_gnt(dbg_gnt),
    .dbg_addra(dbg_addra), .dbg_wea(dbg_wea), .dbg_dia(dbg_dia),
    .dbg_re(dbg_re), .dbg_addrb(dbg_addrb), .dbg_dob(dbg_dob),
    .dbg_rvalid(dbg_rvalid), .dbg_timeout(dbg_timeout),
    .addra(addra), .wea(wea), .dia(dia), .addrb(addrb), .dob(dob)
  );

  always #5 clk = ~clk;

  // BRAM model: byte-enabled write on port A, registered read on port B.
  logic [DW-1:0] mem [0:63];
  always @(posedge clk) begin
    for (int b = 0; b < 4; b++)
      if (wea[b]) mem[addra[7:2]][b*8 +: 8] <= dia[b*8 +: 8];
    dob <= mem[addrb[7:2]];
  end

  typedef struct {
    logic [AW-1:0] wa;
    logic [3:0]    we;
    logic [DW-1:0] wd;
    logic          re;
    logic [AW-1:0] ra;
    logic          exp_rv;
    logic [DW-1:0] exp_dob;
  } vec_t;

  vec_t vecs [10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    cpu_addra = '0; cpu_wea = '0; cpu_dia = '0; cpu_re = 1'b0; cpu_addrb = '0;
    dbg_addra = '0; dbg_wea = '0; dbg_dia = '0; dbg_re = 1'b0; dbg_addrb = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{16'h0010, 4'hF, 32'hDEADBEEF, 1'b0, 16'h0000, 1'b0, 32'h0};
    vecs[1] = '{16'h0024, 4'hF, 32'h0BADF00D, 1'b1, 16'h0010, 1'b0, 32'h0};
    vecs[2] = '{16'h0014, 4'hF, 32'hA5A51234, 1'b0, 16'h0000, 1'b1, 32'hDEADBEEF};
    vecs[3] = '{16'h0030, 4'h0, 32'hCAFE0000, 1'b1, 16'h0024, 1'b0, 32'h0};
    vecs[4] = '{16'h0010, 4'h8, 32'h11000000, 1'b1, 16'h0014, 1'b1, 32'h0BADF00D};
    vecs[5] = '{16'h0000, 4'h0, 32'h00000000, 1'b1, 16'h0010, 1'b1, 32'hA5A51234};
    vecs[6] = '{16'h0000, 4'h0, 32'h00000000, 1'b0, 16'h0000, 1'b1, 32'h11ADBEEF};
    vecs[7] = '{16'h0014, 4'h3, 32'h00005678, 1'b0, 16'h0000, 1'b0, 32'h0};
    vecs[8] = '{16'h0000, 4'h0, 32'h00000000, 1'b1, 16'h0014, 1'b0, 32'h0};
    vecs[9] = '{16'h0000, 4'h0, 32'h00000000, 1'b0, 16'h0000, 1'b1, 32'hA5A55678};

    // Reset: outputs idle even with live CPU inputs.
    rst_n = 1'b0; dbg_req = 1'b0; clear_inputs();
    cpu_addra = 16'h1234; cpu_wea = 4'hF; cpu_dia = 32'h5555AAAA;
    cpu_re = 1'b1; cpu_addrb = 16'h4321;
    tick(); tick();
    smp();
    chk("rst_wea", 32'(wea), 32'h0);
    chk("rst_addra", 32'(addra), 32'h0);
    chk("rst_addrb", 32'(addrb), 32'h0);
    chk("rst_dia", dia, 32'h0);
    chk("rst_stall", 32'(cpu_stall), 32'h0);
    chk("rst_gnt", 32'(dbg_gnt), 32'h0);
    chk("rst_rvalid", {30'h0, cpu_rvalid, dbg_rvalid}, 32'h0);
    chk("rst_timeout", 32'(dbg_timeout), 32'h0);
    tick();
    rst_n = 1'b1; clear_inputs();

    // CPU-only traffic.
    for (int i = 0; i < 10; i++) begin
      cpu_addra = vecs[i].wa; cpu_wea = vecs[i].we; cpu_dia = vecs[i].wd;
      cpu_re = vecs[i].re; cpu_addrb = vecs[i].ra;
      smp();
      chk($sformatf("v%0d_addra", i), 32'(addra), 32'(vecs[i].wa));
      chk($sformatf("v%0d_wea", i), 32'(wea), 32'(vecs[i].we));
      chk($sformatf("v%0d_dia", i), dia, vecs[i].wd);
      chk($sformatf("v%0d_addrb", i), 32'(addrb), 32'(vecs[i].ra));
      chk($sformatf("v%0d_stall", i), 32'(cpu_stall), 32'h0);
      chk($sformatf("v%0d_cpu_rvalid", i), 32'(cpu_rvalid), 32'(vecs[i].exp_rv));
      chk($sformatf("v%0d_dbg_rvalid", i), 32'(dbg_rvalid), 32'h0);
      if (vecs[i].exp_rv) chk($sformatf("v%0d_cpu_dob", i), cpu_dob, vecs[i].exp_dob);
      tick();
    end

    // Handover with a CPU read issued in the dbg_req cycle.
    clear_inputs();
    cpu_re = 1'b1; cpu_addrb = 16'h0010; dbg_req = 1'b1;
    smp();
    chk("h0_stall", 32'(cpu_stall), 32'h0);
    tick();
    cpu_wea = 4'hF; cpu_addra = 16'h0010; cpu_dia = 32'hBAD0BAD0;
    smp();
    chk("h1_stall", 32'(cpu_stall), 32'h1);
    chk("h1_gnt", 32'(dbg_gnt), 32'h0);
    chk("h1_wea", 32'(wea), 32'h0);
    chk("h1_addra", 32'(addra), 32'h0010);
    chk("h1_cpu_rvalid", 32'(cpu_rvalid), 32'h1);
    chk("h1_cpu_dob", cpu_dob, 32'h11ADBEEF);
    tick();
    smp();
    chk("h2_gnt", 32'(dbg_gnt), 32'h0);
    chk("h2_wea", 32'(wea), 32'h0);
    chk("h2_cpu_rvalid", 32'(cpu_rvalid), 32'h0);
    tick();

    // Debug session; CPU keeps driving writes and reads that must be ignored.
    dbg_addra = 16'h0020; dbg_wea = 4'hF; dbg_dia = 32'h12345678;
    smp();
    chk("h3_gnt", 32'(dbg_gnt), 32'h1);
    chk("h3_stall", 32'(cpu_stall), 32'h1);
    chk("h3_wea", 32'(wea), 32'hF);
    chk("h3_addra", 32'(addra), 32'h0020);
    chk("h3_dia", dia, 32'h12345678);
    tick();
    dbg_wea = 4'h0; dbg_re = 1'b1; dbg_addrb = 16'h0020;
    smp();
    chk("h4_wea", 32'(wea), 32'h0);
    chk("h4_addrb", 32'(addrb), 32'h0020);
    tick();
    dbg_addrb = 16'h0024;
    smp();
    chk("h5_dbg_rvalid", 32'(dbg_rvalid), 32'h1);
    chk("h5_dbg_dob", dbg_dob, 32'h12345678);
    chk("h5_cpu_rvalid", 32'(cpu_rvalid), 32'h0);
    tick();
    dbg_re = 1'b0;
    smp();
    chk("h6_dbg_rvalid", 32'(dbg_rvalid), 32'h1);
    chk("h6_dbg_dob_0x24", dbg_dob, 32'h0BADF00D);
    chk("h6_timeout", 32'(dbg_timeout), 32'h0);
    tick();

    // Release in the same cycle as a debug read.
    dbg_re = 1'b1; dbg_addrb = 16'h0010; dbg_req = 1'b0;
    smp();
    chk("h7_gnt", 32'(dbg_gnt), 32'h1);
    tick();
    clear_inputs();
    smp();
    chk("h8_gnt", 32'(dbg_gnt), 32'h0);
    chk("h8_stall", 32'(cpu_stall), 32'h1);
    chk("h8_dbg_rvalid", 32'(dbg_rvalid), 32'h1);
    chk("h8_dbg_dob_0x10", dbg_dob, 32'h11ADBEEF);
    chk("h8_cpu_rvalid", 32'(cpu_rvalid), 32'h0);
    tick();
    smp();
    chk("h9_stall", 32'(cpu_stall), 32'h0);
    chk("h9_cpu_rvalid", 32'(cpu_rvalid), 32'h0);
    tick();

    // Abort from DRAIN.
    dbg_req = 1'b1;
    smp();
    chk("a0_stall", 32'(cpu_stall), 32'h0);
    tick();
    dbg_req = 1'b0;
    smp();
    chk("a1_stall", 32'(cpu_stall), 32'h1);
    chk("a1_gnt", 32'(dbg_gnt), 32'h0);
    tick();
    for (int i = 2; i < 4; i++) begin
      smp();
      chk($sformatf("a%0d_stall", i), 32'(cpu_stall), 32'h0);
      chk($sformatf("a%0d_gnt", i), 32'(dbg_gnt), 32'h0);
      tick();
    end

    // Reset while debug owns the ports, with a read issued that cycle.
    dbg_req = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (dbg_gnt) break;
      tick();
    end
    chk("r_gnt_wait", 32'(dbg_gnt), 32'h1);
    dbg_re = 1'b1; dbg_addrb = 16'h0020; dbg_wea = 4'hF; dbg_addra = 16'h0030;
    dbg_dia = 32'h77777777; rst_n = 1'b0; dbg_req = 1'b0;
    smp();
    chk("r0_gnt", 32'(dbg_gnt), 32'h0);
    chk("r0_stall", 32'(cpu_stall), 32'h0);
    chk("r0_wea", 32'(wea), 32'h0);
    chk("r0_addra", 32'(addra), 32'h0);
    chk("r0_addrb", 32'(addrb), 32'h0);
    chk("r0_dia", dia, 32'h0);
    tick();
    rst_n = 1'b1; clear_inputs();
    smp();
    chk("r1_gnt", 32'(dbg_gnt), 32'h0);
    chk("r1_stall", 32'(cpu_stall), 32'h0);
    chk("r1_rvalid", {30'h0, cpu_rvalid, dbg_rvalid}, 32'h0);
    tick();

    // Idle session: watchdog fires after TIMEOUT_CYCLES, otherwise grant holds.
    begin
      int first_to;
      int n_to;
      first_to = -1;
      n_to = 0;
      dbg_req = 1'b1;
      for (int i = 0; i < 8; i++) begin
        if (dbg_gnt) break;
        tick();
      end
      chk("w_gnt_wait", 32'(dbg_gnt), 32'h1);
      for (int i = 0; i < 14; i++) begin
        smp();
        if (dbg_timeout) begin
          n_to++;
          if (first_to < 0) first_to = i;
        end
`ifdef MEM_ARB_WATCHDOG_EN
        if (i == 9) begin
          chk("w9_gnt", 32'(dbg_gnt), 32'h0);
          chk("w9_stall", 32'(cpu_stall), 32'h1);
        end
        if (i == 13) begin
          chk("w13_gnt_locked", 32'(dbg_gnt), 32'h0);
          chk("w13_stall", 32'(cpu_stall), 32'h0);
        end
`else
        if (i == 13) chk("w13_gnt_held", 32'(dbg_gnt), 32'h1);
`endif
        tick();
      end
`ifdef MEM_ARB_WATCHDOG_EN
      chk("w_timeout_pulses", 32'(n_to), 32'd1);
      chk("w_timeout_cycle", 32'(first_to), 32'd8);
`else
      chk("w_timeout_pulses", 32'(n_to), 32'd0);
`endif
      dbg_req = 1'b0;
      for (int i = 0; i < 4; i++) tick();
      smp();
      chk("w_end_stall", 32'(cpu_stall), 32'h0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
